// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer: registered actuator stage for the irrigation decision
// logic. It synchronises the decision inputs and drives the drip, sprinkler and
// inlet valves plus the alarm. On top of the decisions it enforces a minimum
// valve on-time, a dead time between irrigation modes, drip/sprinkler mutual
// exclusion and a latched fault that needs an operator acknowledge.
//
// Build option: define IRRIG_ALARM_BLINK_EN to make the alarm blink with a
// half-period of BLINK cycles. Without it the alarm is steady and no blink
// counter exists.
//
// The FSM state is exported on the 'state' port for observation:
// IDLE=0, DRIP=1, SPRAY=2, DWELL=3, FAULT=4.
module irrigation_sequencer #(
  parameter int MIN_ON = 8,
  parameter int DEAD   = 4,
  parameter int CNT_W  = 8,
  parameter int BLINK  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs_req,
  input  logic       bs_req,
  input  logic       ve_req,
  input  logic       al_req,
  input  logic       erro,
  input  logic       ack,
  output logic       valve_drip,
  output logic       valve_spray,
  output logic       valve_inlet,
  output logic       alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIP  = 3'd1,
    ST_SPRAY = 3'd2,
    ST_DWELL = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);

  // Reject parameter values outside their legal ranges at elaboration
  if (MIN_ON < 1 || MIN_ON > (1 << CNT_W) - 1 ||
      DEAD < 1   || DEAD > (1 << CNT_W) - 1 ||
      BLINK < 1  || BLINK > (1 << CNT_W) - 1) begin : g_bad_params
    $error("irrigation_sequencer: MIN_ON, DEAD or BLINK out of range for CNT_W");
  end

  // Synchroniser flops; bit order {ack, erro, al, ve, bs, vs}
  logic [5:0] sync1_q, sync2_q;
  logic       vs_s, bs_s, ve_s, al_s, erro_s, ack_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_lim;

  logic drip_q, spray_q, inlet_q, alarm_q;
  logic drip_d, spray_d, inlet_d, alarm_d;
  logic alarm_cond;

  assign vs_s   = sync2_q[0];
  assign bs_s   = sync2_q[1];
  assign ve_s   = sync2_q[2];
  assign al_s   = sync2_q[3];
  assign erro_s = sync2_q[4];
  assign ack_s  = sync2_q[5];

  // Two-flop synchroniser on every request input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {ack, erro, al_req, ve_req, bs_req, vs_req};
      sync2_q <= sync1_q;
    end
  end

  // State register and shared state timer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and timer logic; erro_s wins over everything in every state
  always_comb begin
    state_d   = state_q;
    timer_lim = '0;
    case (state_q)
      ST_IDLE: begin
        if (erro_s)     state_d = ST_FAULT;
        else if (bs_s)  state_d = ST_SPRAY;
        else if (vs_s)  state_d = ST_DRIP;
      end
      ST_DRIP: begin
        timer_lim = ON_LAST;
        if (erro_s)                                    state_d = ST_FAULT;
        else if (timer_q == ON_LAST && (!vs_s || bs_s)) state_d = ST_DWELL;
      end
      ST_SPRAY: begin
        timer_lim = ON_LAST;
        if (erro_s)                           state_d = ST_FAULT;
        else if (timer_q == ON_LAST && !bs_s) state_d = ST_DWELL;
      end
      ST_DWELL: begin
        timer_lim = DEAD_LAST;
        if (erro_s)                  state_d = ST_FAULT;
        else if (timer_q == DEAD_LAST) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!erro_s && ack_s) state_d = ST_DWELL;
      end
      default: state_d = ST_IDLE;
    endcase

    // Timer restarts on every state change and saturates at the state's limit
    if (state_d != state_q)       timer_d = '0;
    else if (timer_q == timer_lim) timer_d = timer_q;
    else                           timer_d = timer_q + 1'b1;
  end

  // Output decode from the next state so outputs move with the state
  always_comb begin
    drip_d     = (state_d == ST_DRIP);
    spray_d    = (state_d == ST_SPRAY);
    inlet_d    = ve_s && (state_d != ST_FAULT);
    alarm_cond = al_s || (state_d == ST_FAULT);
  end

`ifdef IRRIG_ALARM_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK - 1);

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;
  logic             blink_act_q;

  // Blink phase: starts in the on phase when the condition first appears
  always_comb begin
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    if (alarm_cond) begin
      if (!blink_act_q) begin
        blink_ph_d = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_ph_d = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
      end
    end
    alarm_d = alarm_cond && blink_ph_d;
  end

  // Blink counter, independent of the FSM timer
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      blink_act_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      blink_act_q <= alarm_cond;
    end
  end
`else
  assign alarm_d = alarm_cond;
`endif

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      drip_q  <= 1'b0;
      spray_q <= 1'b0;
      inlet_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      drip_q  <= drip_d;
      spray_q <= spray_d;
      inlet_q <= inlet_d;
      alarm_q <= alarm_d;
    end
  end

  assign valve_drip  = drip_q;
  assign valve_spray = spray_q;
  assign valve_inlet = inlet_q;
  assign alarm       = alarm_q;
  assign state       = state_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Testbench for irrigation_sequencer (MIN_ON=4, DEAD=2, BLINK=3).
// Table-driven vectors, hand sequences for multi-cycle corners, then random
// stimulus against a behavioural reference model.
module tb_irrigation_sequencer;

  localparam int MIN_ON = 4;
  localparam int DEAD   = 2;
  localparam int CNT_W  = 8;
  localparam int BLINK  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_DRIP  = 1;
  localparam int M_SPRAY = 2;
  localparam int M_DWELL = 3;
  localparam int M_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst, vs_req, bs_req, ve_req, al_req, erro, ack;
  logic       valve_drip, valve_spray, valve_inlet, alarm;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  irrigation_sequencer #(
    .MIN_ON(MIN_ON), .DEAD(DEAD), .CNT_W(CNT_W), .BLINK(BLINK)
  ) dut (
    .clk(clk), .rst(rst),
    .vs_req(vs_req), .bs_req(bs_req), .ve_req(ve_req), .al_req(al_req),
    .erro(erro), .ack(ack),
    .valve_drip(valve_drip), .valve_spray(valve_spray),
    .valve_inlet(valve_inlet), .alarm(alarm), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Requests seen by the decision rules are the samples taken two edges ago.
  logic [5:0] hist[$];   // {ack, erro, al, ve, bs, vs}
  int   m_mode, m_age, m_run;
  logic m_drip, m_spray, m_inlet, m_alarm;

  task automatic model_step();
    logic [5:0] s;
    int   nxt;
    logic cond;
    if (rst) begin
      hist.delete();
      hist.push_back(6'd0);
      hist.push_back(6'd0);
      m_mode = M_IDLE; m_age = 0; m_run = -1;
      m_drip = 0; m_spray = 0; m_inlet = 0; m_alarm = 0;
      return;
    end
    s = hist.pop_front();
    hist.push_back({ack, erro, al_req, ve_req, bs_req, vs_req});
    nxt = m_mode;
    if (s[4]) begin
      if (m_mode != M_FAULT) nxt = M_FAULT;
    end else begin
      case (m_mode)
        M_IDLE:  if (s[1]) nxt = M_SPRAY; else if (s[0]) nxt = M_DRIP;
        M_DRIP:  if (m_age >= MIN_ON - 1 && (!s[0] || s[1])) nxt = M_DWELL;
        M_SPRAY: if (m_age >= MIN_ON - 1 && !s[1]) nxt = M_DWELL;
        M_DWELL: if (m_age >= DEAD - 1) nxt = M_IDLE;
        default: if (s[5]) nxt = M_DWELL;
      endcase
    end
    m_age  = (nxt != m_mode) ? 0 : m_age + 1;
    m_mode = nxt;
    m_drip  = (m_mode == M_DRIP);
    m_spray = (m_mode == M_SPRAY);
    m_inlet = s[2] && (m_mode != M_FAULT);
    cond    = s[3] || (m_mode == M_FAULT);
    m_run   = cond ? m_run + 1 : -1;
`ifdef IRRIG_ALARM_BLINK_EN
    m_alarm = cond && (((m_run / BLINK) % 2) == 0);
`else
    m_alarm = cond;
`endif
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, step the model and compare
  task automatic apply(input logic r, v, b, e, a, er, ak);
    @(negedge clk);
    rst = r; vs_req = v; bs_req = b; ve_req = e; al_req = a; erro = er; ack = ak;
    @(posedge clk);
    model_step();
    #1;
    check("model_state", {5'd0, state}, 8'(m_mode));
    check("model_drip",  {7'd0, valve_drip},  {7'd0, m_drip});
    check("model_spray", {7'd0, valve_spray}, {7'd0, m_spray});
    check("model_inlet", {7'd0, valve_inlet}, {7'd0, m_inlet});
    check("model_alarm", {7'd0, alarm},       {7'd0, m_alarm});
    check("no_overlap",  {7'd0, valve_drip & valve_spray}, 8'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       rst, vs, bs, ve, al, erro, ack;
    logic [2:0] st;
    logic       drip, spray, inlet, alarm;
  } vec_t;

  function automatic vec_t mk(input logic r, v, b, e, a, er, ak,
                              input logic [2:0] st, input logic d, sp, in, al);
    vec_t x;
    x.rst = r; x.vs = v; x.bs = b; x.ve = e; x.al = a; x.erro = er; x.ack = ak;
    x.st = st; x.drip = d; x.spray = sp; x.inlet = in; x.alarm = al;
    return x;
  endfunction

  localparam int NV = 21;
  vec_t tbl[NV];

  initial begin
    int   gap, overlap, dwell;
    logic rose, fell, prev_drip, reached;

    rst = 1; vs_req = 0; bs_req = 0; ve_req = 0; al_req = 0; erro = 0; ack = 0;
    hist.push_back(6'd0);
    hist.push_back(6'd0);
    m_mode = M_IDLE; m_age = 0; m_run = -1;
    m_drip = 0; m_spray = 0; m_inlet = 0; m_alarm = 0;

    // Reset with requests high, release, spray after two edges, then drop
    tbl[0]  = mk(1,1,1,1,1,0,0, 3'd0,0,0,0,0);
    tbl[1]  = mk(1,1,1,1,1,0,0, 3'd0,0,0,0,0);
    tbl[2]  = mk(0,1,1,1,1,0,0, 3'd0,0,0,0,0);
    tbl[3]  = mk(0,1,1,1,1,0,0, 3'd0,0,0,0,0);
    tbl[4]  = mk(0,1,1,1,0,0,0, 3'd2,0,1,1,1);
    tbl[5]  = mk(0,1,1,1,0,0,0, 3'd2,0,1,1,1);
    tbl[6]  = mk(0,0,0,0,0,0,0, 3'd2,0,1,1,0);
    tbl[7]  = mk(0,0,0,0,0,0,0, 3'd2,0,1,1,0);
    tbl[8]  = mk(0,0,0,0,0,0,0, 3'd3,0,0,0,0);
    tbl[9]  = mk(0,0,0,0,0,0,0, 3'd3,0,0,0,0);
    tbl[10] = mk(0,0,0,0,0,0,0, 3'd0,0,0,0,0);
    tbl[11] = mk(0,0,0,0,0,0,0, 3'd0,0,0,0,0);
    // Single-cycle drip pulse: drip held for MIN_ON cycles, DWELL 2, IDLE
    tbl[12] = mk(0,1,0,0,0,0,0, 3'd0,0,0,0,0);
    tbl[13] = mk(0,0,0,0,0,0,0, 3'd0,0,0,0,0);
    tbl[14] = mk(0,0,0,0,0,0,0, 3'd1,1,0,0,0);
    tbl[15] = mk(0,0,0,0,0,0,0, 3'd1,1,0,0,0);
    tbl[16] = mk(0,0,0,0,0,0,0, 3'd1,1,0,0,0);
    tbl[17] = mk(0,0,0,0,0,0,0, 3'd1,1,0,0,0);
    tbl[18] = mk(0,0,0,0,0,0,0, 3'd3,0,0,0,0);
    tbl[19] = mk(0,0,0,0,0,0,0, 3'd3,0,0,0,0);
    tbl[20] = mk(0,0,0,0,0,0,0, 3'd0,0,0,0,0);

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].rst, tbl[i].vs, tbl[i].bs, tbl[i].ve, tbl[i].al, tbl[i].erro, tbl[i].ack);
      check($sformatf("vec%0d", i),
            {1'b0, state, valve_drip, valve_spray, valve_inlet, alarm},
            {1'b0, tbl[i].st, tbl[i].drip, tbl[i].spray, tbl[i].inlet, tbl[i].alarm});
    end

    // Mode switch: drip held, sprinkler raised 6 cycles later
    idle_cycles(4);
    gap = 0; overlap = 0; rose = 0; fell = 0; prev_drip = 0;
    for (int i = 0; i < 40 && !rose; i++) begin
      apply(0, 1, (i >= 6), 0, 0, 0, 0);
      if (valve_drip && valve_spray) overlap++;
      if (prev_drip && !valve_drip) fell = 1;
      if (fell && !valve_drip && !valve_spray) gap++;
      if (valve_spray) rose = 1;
      prev_drip = valve_drip;
    end
    check("switch_spray_rose", {7'd0, rose}, 8'd1);
    check("switch_drip_fell",  {7'd0, fell}, 8'd1);
    check("switch_gap",        8'(gap), 8'(DEAD + 1));
    check("switch_overlap",    8'(overlap), 8'd0);
    idle_cycles(10);

    // Error one cycle after spray rises; FAULT after two more edges
    rose = 0;
    for (int i = 0; i < 20 && !rose; i++) begin
      apply(0, 0, 1, 1, 0, 0, 0);
      rose = valve_spray;
    end
    check("err_spray_rose", {7'd0, rose}, 8'd1);
    apply(0, 0, 1, 1, 0, 1, 0);
    apply(0, 0, 1, 1, 0, 1, 0);
    check("err_not_yet", {5'd0, state}, 8'd2);
    apply(0, 0, 1, 1, 0, 1, 0);
    check("err_fault", {1'b0, state, valve_drip, valve_spray, valve_inlet, alarm},
          {1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1});
    // ack while erro is still high is ignored
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 1, 0, 1, 1);
    check("ack_ignored", {5'd0, state}, 8'd4);
    // erro gone but no ack yet: fault stays latched
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 0, 0, 0);
    check("fault_latched", {5'd0, state}, 8'd4);
    apply(0, 0, 0, 0, 1, 0, 1);
    dwell = 0; reached = 0;
    for (int i = 0; i < 12 && !reached; i++) begin
      apply(0, 0, 0, 0, 1, 0, 0);
      if (state == 3'd3) dwell++;
      if (dwell > 0 && state == 3'd0) reached = 1;
    end
    check("recover_idle",  {7'd0, reached}, 8'd1);
    check("recover_dwell", 8'(dwell), 8'(DEAD));
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 0);
    check("alarm_follows_al", {7'd0, alarm}, 8'd0);

    // Reset asserted mid-drip clears everything after one edge
    rose = 0;
    for (int i = 0; i < 20 && !rose; i++) begin
      apply(0, 1, 0, 1, 1, 0, 0);
      rose = valve_drip;
    end
    check("midrst_drip_rose", {7'd0, rose}, 8'd1);
    apply(1, 1, 0, 1, 1, 0, 0);
    check("midrst_clear", {1'b0, state, valve_drip, valve_spray, valve_inlet, alarm}, 8'd0);
    idle_cycles(4);

`ifdef IRRIG_ALARM_BLINK_EN
    // Held alarm request blinks with BLINK-cycle half period, starting high
    apply(0, 0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4 * BLINK; k++) begin
      apply(0, 0, 0, 0, 1, 0, 0);
      check($sformatf("blink%0d", k), {7'd0, alarm}, {7'd0, ((k / BLINK) % 2) == 0});
    end
    idle_cycles(4);
`endif

    // Random stimulus against the model
    begin
      logic v, b, e, a, er;
      v = 0; b = 0; e = 0; a = 0; er = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) v = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) b = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) e = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) a = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 29) == 0) er = ($urandom_range(0, 2) == 0);
        apply(($urandom_range(0, 299) == 0), v, b, e, a, er, ($urandom_range(0, 5) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
